beat_sequencer: RTL and testbench

Playback-side reader for the game's note chart: walks the beat ROM one step at a time, every 0.1 s, over a 16-bit address / 4-bit lane-mask read port with 1-cycle registered latency. For each step it emits a one-cycle per-lane spawn pulse. It sits between the game control FSM (start/pause/abort) and the note-falling/render logic, and signals end-of-song.

---
 rtl/beat_pkg.sv | 20 ++
 rtl/step_timer.sv | 29 ++
 rtl/beat_sequencer.sv | 125 ++++++++++++
 tb/tb_beat_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// Constants and FSM state type shared by the beat sequencer, the chart ROM and
// the note renderer.
package beat_pkg;

    localparam int unsigned BEAT_CLK_HZ = 100_000_000;
    // One chart step lasts 0.1 s.
    localparam int unsigned STEP_PERIOD = BEAT_CLK_HZ / 10;
    localparam int unsigned BEAT_DEPTH  = 600;
    localparam int unsigned BEAT_LANES  = 4;
    localparam int unsigned BEAT_ADDR_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StRead,
        StWait,
        StDone
    } seq_state_t;

endpackage

// File: rtl/step_timer.sv
// Per-step tick counter: flags the final clock of a chart step.
module step_timer #(
    parameter int unsigned TICK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_last
);

    localparam int unsigned      CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/beat_sequencer.sv
// Chart playback reader: fetches one lane mask per step from the beat ROM and
// emits a one-cycle spawn pulse for it, paced by step_timer.
module beat_sequencer
    import beat_pkg::*;
#(
    parameter int unsigned CLK_HZ   = BEAT_CLK_HZ,
    parameter int unsigned TICK_DIV = CLK_HZ / 10,
    parameter int unsigned DEPTH    = BEAT_DEPTH,
    parameter int unsigned ADDR_W   = BEAT_ADDR_W,
    parameter int unsigned LANES    = BEAT_LANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [LANES-1:0]  rom_data,
    output logic [LANES-1:0]  spawn,
    output logic              spawn_valid,
    output logic [ADDR_W-1:0] step_idx,
    output logic              playing,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(DEPTH - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_d;
    logic [ADDR_W-1:0] r_step_idx;
    logic [ADDR_W-1:0] w_step_d;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [LANES-1:0]  r_spawn;
    logic              r_spawn_valid;
    logic              w_last;
    logic              w_expire;
    logic              w_timer_clear;
    logic              w_timer_en;

    assign w_expire = (r_state == StWait) && !pause && w_last;

    // Fetch cycles always count; WAIT counts only while unpaused.
    assign w_timer_en    = (r_state == StIssue) || (r_state == StRead) ||
                           ((r_state == StWait) && !pause);
    assign w_timer_clear = (w_state_d == StIdle) || (w_state_d == StIssue) ||
                           (w_state_d == StDone);

    step_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_step_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_last   (w_last)
    );

    always_comb begin
        w_state_d = r_state;
        w_step_d  = r_step_idx;
        unique case (r_state)
            StIdle: begin
                w_step_d = '0;
                if (start) begin
                    w_state_d = StIssue;
                end
            end
            StIssue: w_state_d = StRead;
            StRead:  w_state_d = StWait;
            StWait: begin
                if (w_expire) begin
                    if (r_step_idx == LAST_STEP) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StIssue;
                        w_step_d  = r_step_idx + ADDR_W'(1);
                    end
                end
            end
            StDone: begin
                if (start) begin
                    w_state_d = StIssue;
                    w_step_d  = '0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_step_d  = '0;
            end
        endcase
        if (abort) begin
            w_state_d = StIdle;
            w_step_d  = '0;
        end
    end

    // rom_addr follows the next step index so the ROM sees it during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_step_idx    <= '0;
            r_rom_addr    <= '0;
            r_spawn       <= '0;
            r_spawn_valid <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_step_idx    <= w_step_d;
            r_rom_addr    <= w_step_d;
            r_spawn_valid <= (r_state == StRead) && !abort;
            if (abort) begin
                r_spawn <= '0;
            end else if (r_state == StRead) begin
                r_spawn <= rom_data;
            end
        end
    end

    assign rom_addr    = r_rom_addr;
    assign spawn       = r_spawn;
    assign spawn_valid = r_spawn_valid;
    assign step_idx    = r_step_idx;
    assign playing     = (r_state == StIssue) || (r_state == StRead) || (r_state == StWait);
    assign done        = (r_state == StDone);

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: scenario table, reset corner case and random
// stimulus, all checked against a step/age playback model.
module tb_beat_sequencer;

    localparam int TICK = 8;
    localparam int NSTEP = 4;
    localparam int RUN = 90;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic        abort;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  spawn;
    logic        spawn_valid;
    logic [15:0] step_idx;
    logic        playing;
    logic        done;

    beat_sequencer #(
        .CLK_HZ   (80),
        .TICK_DIV (TICK),
        .DEPTH    (NSTEP),
        .ADDR_W   (16),
        .LANES    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .spawn       (spawn),
        .spawn_valid (spawn_valid),
        .step_idx    (step_idx),
        .playing     (playing),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rom [4];
    initial begin
        rom[0] = 4'b0001;
        rom[1] = 4'b0000;
        rom[2] = 4'b1010;
        rom[3] = 4'b1111;
    end
    always @(posedge clk) rom_data <= rom[rom_addr[1:0]];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Playback model: mode 0 idle / 1 playing / 2 done; age = cycles since the
    // step's fetch, not counting paused waiting cycles.
    int         m_mode, m_step, m_age;
    bit         m_sv, m_nsv;
    logic [3:0] m_spawn;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_step = 0; m_age = 0; m_sv = 0; m_spawn = 4'h0;
        end else begin
            m_nsv = 0;
            if (abort) begin
                m_mode = 0; m_step = 0; m_age = 0;
            end else if (m_mode != 1) begin
                if (start) begin
                    m_mode = 1; m_step = 0; m_age = 0;
                end
            end else if (m_age < 2) begin
                if (m_age == 1) begin
                    m_nsv = 1;
                    m_spawn = rom[m_step];
                end
                m_age++;
            end else if (!pause) begin
                if (m_age == TICK - 1) begin
                    if (m_step == NSTEP - 1) m_mode = 2;
                    else begin
                        m_step++;
                        m_age = 0;
                    end
                end else m_age++;
            end
            m_sv = m_nsv;
        end
    end

    // Per-cycle model check plus event recording for the scenario table.
    bit         rec_en = 0;
    bit         prev_done = 0;
    int         q_sc[$];
    logic [3:0] q_sm[$];
    int         q_dc[$];

    always @(negedge clk) begin
        chk("playing", 32'(playing), 32'(m_mode == 1));
        chk("done", 32'(done), 32'(m_mode == 2));
        chk("spawn_valid", 32'(spawn_valid), 32'(m_sv));
        if (m_sv) chk("spawn", 32'(spawn), 32'(m_spawn));
        if (m_mode != 2) chk("step_idx", 32'(step_idx), m_step);
        if (m_mode == 0 || (m_mode == 1 && m_age == 0)) chk("rom_addr", 32'(rom_addr), m_step);
        if (rec_en) begin
            if (spawn_valid) begin
                q_sc.push_back(cyc);
                q_sm.push_back(spawn);
            end
            if (done && !prev_done) q_dc.push_back(cyc);
        end
        prev_done = done;
    end

    typedef struct packed {
        int          start_at;
        int          start2_at;
        int          pause_at;
        int          pause_len;
        int          abort_at;
        int          n_spawn;
        logic [63:0] sc;
        logic [31:0] sm;
        int          n_done;
        logic [15:0] dc;
    } vec_t;

    vec_t tbl[5];

    task automatic drive_cycle(input int c, input bit st, input bit pa, input bit ab);
        @(posedge clk);
        cyc = c;
        #1;
        start = st;
        pause = pa;
        abort = ab;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        start = 0; pause = 0; abort = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        q_sc.delete(); q_sm.delete(); q_dc.delete();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        do_reset();
        rec_en = 1;
        for (int c = 0; c < RUN; c++) begin
            drive_cycle(c, (c == v.start_at) || (c == v.start2_at),
                        (c >= v.pause_at) && (c < v.pause_at + v.pause_len),
                        c == v.abort_at);
        end
        drive_cycle(RUN, 0, 0, 0);
        rec_en = 0;
        chk($sformatf("vec%0d n_spawn", idx), q_sc.size(), v.n_spawn);
        for (int i = 0; i < v.n_spawn; i++) begin
            if (i < q_sc.size()) begin
                chk($sformatf("vec%0d spawn%0d cycle", idx, i), q_sc[i], 32'(v.sc[8*i +: 8]));
                chk($sformatf("vec%0d spawn%0d mask", idx, i), 32'(q_sm[i]), 32'(v.sm[4*i +: 4]));
            end
        end
        chk($sformatf("vec%0d n_done", idx), q_dc.size(), v.n_done);
        for (int i = 0; i < v.n_done; i++) begin
            if (i < q_dc.size()) chk($sformatf("vec%0d done%0d cycle", idx, i), q_dc[i],
                                     32'(v.dc[8*i +: 8]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; pause = 0; abort = 0;

        // start, start2, pause_at, pause_len, abort, n_spawn, cycles, masks, n_done, done cycles
        tbl[0] = '{10, -1, -1, 0, -1, 4, {32'd0, 8'd37, 8'd29, 8'd21, 8'd13},
                   {16'h0, 4'hF, 4'hA, 4'h0, 4'h1}, 1, {8'd0, 8'd43}};
        tbl[1] = '{10, -1, 15, 5, -1, 4, {32'd0, 8'd42, 8'd34, 8'd26, 8'd13},
                   {16'h0, 4'hF, 4'hA, 4'h0, 4'h1}, 1, {8'd0, 8'd48}};
        tbl[2] = '{10, -1, -1, 0, 22, 2, {48'd0, 8'd21, 8'd13},
                   {24'h0, 4'h0, 4'h1}, 0, 16'd0};
        tbl[3] = '{10, 18, -1, 0, -1, 4, {32'd0, 8'd37, 8'd29, 8'd21, 8'd13},
                   {16'h0, 4'hF, 4'hA, 4'h0, 4'h1}, 1, {8'd0, 8'd43}};
        tbl[4] = '{10, 45, -1, 0, -1, 8,
                   {8'd72, 8'd64, 8'd56, 8'd48, 8'd37, 8'd29, 8'd21, 8'd13},
                   {4'hF, 4'hA, 4'h0, 4'h1, 4'hF, 4'hA, 4'h0, 4'h1}, 2, {8'd78, 8'd43}};

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("reset playing", 32'(playing), 0);
        chk("reset done", 32'(done), 0);
        chk("reset spawn_valid", 32'(spawn_valid), 0);
        chk("reset step_idx", 32'(step_idx), 0);

        for (int i = 0; i < 5; i++) run_vec(i, tbl[i]);

        // Asynchronous reset in the middle of a step's wait.
        do_reset();
        for (int c = 0; c < 17; c++) drive_cycle(c, c == 10, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst playing", 32'(playing), 0);
        chk("async rst spawn_valid", 32'(spawn_valid), 0);
        chk("async rst spawn", 32'(spawn), 0);
        chk("async rst step_idx", 32'(step_idx), 0);
        chk("async rst rom_addr", 32'(rom_addr), 0);
        chk("async rst done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        q_sc.delete(); q_sm.delete(); q_dc.delete();
        rec_en = 1;
        for (int c = 20; c < 40; c++) drive_cycle(c, c == 30, 0, 0);
        rec_en = 0;
        chk("post-reset n_spawn", q_sc.size(), 1);
        if (q_sc.size() > 0) chk("post-reset spawn cycle", q_sc[0], 33);

        // Random control traffic, checked cycle by cycle against the model.
        do_reset();
        begin
            bit pz = 0;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(7) == 0) pz = ~pz;
                drive_cycle(c, $urandom_range(15) == 0, pz, $urandom_range(79) == 0);
            end
        end
        drive_cycle(3000, 0, 0, 0);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
